treasure_scan_ctrl: RTL and testbench

Sequences the per-frame treasure image processor on behalf of the Arduino. On a scan request it arms the processor on frame boundaries and collects one 4-bit result per frame. It reports only a result that repeats on `AGREE_FRAMES` consecutive frames, or a timeout after `MAX_FRAMES`, over a 4-phase VALID/ACK handshake on the parallel link to the Arduino. It sits between the image processor outputs and the FPGA-to-Arduino GPIO pins.

---
 rtl/treasure_pkg.sv | 37 +++
 rtl/sync_edge.sv | 37 +++
 rtl/treasure_scan_ctrl.sv | 116 +++++++++++
 tb/tb_treasure_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/treasure_pkg.sv
// Shared encodings for the treasure scan controller: result fields, colour/shape codes, FSM states.
package treasure_pkg;

    localparam int unsigned RESULT_W   = 4;
    localparam int unsigned COLOUR_MSB = 3;
    localparam int unsigned COLOUR_LSB = 2;
    localparam int unsigned SHAPE_MSB  = 1;
    localparam int unsigned SHAPE_LSB  = 0;

    localparam logic [1:0] COLOUR_NONE = 2'd0;
    localparam logic [1:0] COLOUR_BLUE = 2'd1;
    localparam logic [1:0] COLOUR_RED  = 2'd2;

    localparam logic [1:0] SHAPE_NONE     = 2'd0;
    localparam logic [1:0] SHAPE_TRIANGLE = 2'd1;
    localparam logic [1:0] SHAPE_SQUARE   = 2'd2;
    localparam logic [1:0] SHAPE_DIAMOND  = 2'd3;

    // One-hot so that ARD_VALID and BUSY are single-register decodes.
    typedef enum logic [4:0] {
        ST_IDLE       = 5'b00001,
        ST_WAIT_FRAME = 5'b00010,
        ST_CAPTURE    = 5'b00100,
        ST_REPORT     = 5'b01000,
        ST_ACK_LOW    = 5'b10000
    } state_t;

    function automatic logic [RESULT_W-1:0] make_result(input logic [1:0] colour,
                                                        input logic [1:0] shape);
        logic [RESULT_W-1:0] r;
        r = '0;
        r[COLOUR_MSB:COLOUR_LSB] = colour;
        r[SHAPE_MSB:SHAPE_LSB]   = shape;
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer; with EDGE set, q is a one-cycle pulse on a synchronized rising edge.
module sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic s3;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s3 <= 1'b0;
                else        s3 <= s2;
            end
            assign q = s2 & ~s3;
        end else begin : g_level
            assign q = s2;
        end
    endgenerate

endmodule

// File: rtl/treasure_scan_ctrl.sv
// Runs one treasure scan: captures per-frame results, reports an agreed result or a timeout
// to the Arduino over a 4-phase VALID/ACK handshake.
module treasure_scan_ctrl
    import treasure_pkg::*;
#(
    parameter int unsigned AGREE_FRAMES = 3,
    parameter int unsigned MAX_FRAMES   = 15
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                SCAN_REQ,
    input  logic                VGA_VSYNC_NEG,
    input  logic [RESULT_W-1:0] IP_RESULT,
    input  logic                IP_RDY,
    input  logic                ARD_ACK,
    output logic [RESULT_W-1:0] ARD_DATA,
    output logic                ARD_VALID,
    output logic                ARD_TIMEOUT,
    output logic                BUSY
);

    localparam logic [3:0] AGREE_W = 4'(AGREE_FRAMES);
    localparam logic [3:0] MAX_W   = 4'(MAX_FRAMES);

    state_t              state;
    logic [RESULT_W-1:0] cand;
    logic [3:0]          agree_cnt;
    logic [3:0]          frame_cnt;
    logic                rdy_d;
    logic                vs_d;
    logic                req_rise;
    logic                ack_s;
    logic                rdy_rise;
    logic                vs_fall;
    logic [3:0]          frame_inc;
    logic [3:0]          agree_nxt;

    sync_edge #(.EDGE(1'b1)) u_req_sync (.clk(CLK), .rst_n(RESET_N), .d(SCAN_REQ), .q(req_rise));
    sync_edge #(.EDGE(1'b0)) u_ack_sync (.clk(CLK), .rst_n(RESET_N), .d(ARD_ACK),  .q(ack_s));

    assign rdy_rise  = IP_RDY & ~rdy_d;
    assign vs_fall   = vs_d & ~VGA_VSYNC_NEG;
    assign ARD_VALID = (state == ST_REPORT);
    assign BUSY      = (state != ST_IDLE);

    // A new result either extends the current run or starts a fresh run of one.
    always_comb begin
        frame_inc = frame_cnt + 4'd1;
        agree_nxt = 4'd1;
        if (agree_cnt != 4'd0 && IP_RESULT == cand) agree_nxt = agree_cnt + 4'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            cand        <= '0;
            agree_cnt   <= 4'd0;
            frame_cnt   <= 4'd0;
            rdy_d       <= 1'b0;
            vs_d        <= 1'b0;
            ARD_DATA    <= '0;
            ARD_TIMEOUT <= 1'b0;
        end else begin
            rdy_d <= IP_RDY;
            vs_d  <= VGA_VSYNC_NEG;
            unique case (state)
                ST_IDLE: begin
                    if (req_rise) begin
                        cand      <= '0;
                        agree_cnt <= 4'd0;
                        frame_cnt <= 4'd0;
                        state     <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (!VGA_VSYNC_NEG) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (rdy_rise) begin
                        frame_cnt <= frame_inc;
                        agree_cnt <= agree_nxt;
                        cand      <= IP_RESULT;
                        if (agree_nxt == AGREE_W) begin
                            ARD_DATA    <= IP_RESULT;
                            ARD_TIMEOUT <= 1'b0;
                            state       <= ST_REPORT;
                        end else if (frame_inc == MAX_W) begin
                            ARD_DATA    <= '0;
                            ARD_TIMEOUT <= 1'b1;
                            state       <= ST_REPORT;
                        end else begin
                            state <= ST_WAIT_FRAME;
                        end
                    end else if (vs_fall) begin
                        // Frame ended without a result: it counts, but breaks the run.
                        frame_cnt <= frame_inc;
                        agree_cnt <= 4'd0;
                        if (frame_inc == MAX_W) begin
                            ARD_DATA    <= '0;
                            ARD_TIMEOUT <= 1'b1;
                            state       <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    if (ack_s) state <= ST_ACK_LOW;
                end
                ST_ACK_LOW: begin
                    if (!ack_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_treasure_scan_ctrl.sv
// Self-checking bench: frame-level reference model plus per-cycle output comparison.
module tb_treasure_scan_ctrl;
    import treasure_pkg::*;

    localparam int AGREE = 3;
    localparam int MAXF  = 15;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       SCAN_REQ;
    logic       VGA_VSYNC_NEG;
    logic [3:0] IP_RESULT;
    logic       IP_RDY;
    logic       ARD_ACK;
    logic [3:0] ARD_DATA;
    logic       ARD_VALID;
    logic       ARD_TIMEOUT;
    logic       BUSY;

    treasure_scan_ctrl #(.AGREE_FRAMES(AGREE), .MAX_FRAMES(MAXF)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SCAN_REQ(SCAN_REQ), .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
        .IP_RESULT(IP_RESULT), .IP_RDY(IP_RDY), .ARD_ACK(ARD_ACK), .ARD_DATA(ARD_DATA),
        .ARD_VALID(ARD_VALID), .ARD_TIMEOUT(ARD_TIMEOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Expected outputs, updated by the driver at the cycle the rules say they change.
    logic       exp_busy  = 1'b0;
    logic       exp_valid = 1'b0;
    logic [3:0] exp_data  = 4'd0;
    logic       exp_to    = 1'b0;
    bit         mon_en    = 1'b0;

    // Frame plan for one scan, and the model's verdict on it.
    logic [3:0] fr_res  [1:MAXF];
    bit         fr_miss [1:MAXF];
    int         m_k;
    logic [3:0] m_d;
    bit         m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Report at the first frame closing a run of AGREE captured, identical results; else timeout at MAXF.
    task automatic model();
        bit found;
        bit ok;
        found = 1'b0;
        m_k = MAXF; m_d = 4'd0; m_to = 1'b1;
        for (int i = 1; i <= MAXF; i++) begin
            if (!found && i >= AGREE) begin
                ok = 1'b1;
                for (int j = i - AGREE + 1; j <= i; j++)
                    if (fr_miss[j] || fr_res[j] != fr_res[i]) ok = 1'b0;
                if (ok) begin
                    found = 1'b1; m_k = i; m_d = fr_res[i]; m_to = 1'b0;
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("busy",  32'(BUSY),      32'(exp_busy));
            chk("valid", 32'(ARD_VALID), 32'(exp_valid));
            chk("data",  32'(ARD_DATA),  32'(exp_data));
            if (exp_valid) chk("timeout", 32'(ARD_TIMEOUT), 32'(exp_to));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_report();
        exp_valid = 1'b1;
        exp_data  = m_to ? 4'd0 : m_d;
        exp_to    = m_to;
    endtask

    task automatic drive_frame(input int i, input bit rep, input bit pulse);
        int off;
        VGA_VSYNC_NEG = 1'b0; IP_RDY = 1'b0; IP_RESULT = 4'($urandom);
        tick(2);
        VGA_VSYNC_NEG = 1'b1;
        off = int'($urandom_range(2, 6));
        for (int c = 0; c < 10; c++) begin
            if (c == off && !fr_miss[i]) begin
                IP_RDY = 1'b1; IP_RESULT = fr_res[i];
            end
            if (pulse) SCAN_REQ = (c >= 1 && c <= 5);
            tick(1);
            if (c == off && !fr_miss[i] && rep) set_report();
        end
        if (rep && fr_miss[i]) begin
            VGA_VSYNC_NEG = 1'b0; IP_RDY = 1'b0;
            tick(1);
            set_report();
            tick(1);
            VGA_VSYNC_NEG = 1'b1;
        end
    endtask

    task automatic run_scan(input bit pulse);
        model();
        tick(3);
        SCAN_REQ = 1'b1;
        tick(3);
        exp_busy = 1'b1;
        tick(2);
        SCAN_REQ = 1'b0;
        for (int i = 1; i <= m_k; i++) drive_frame(i, i == m_k, pulse && i == 4);
        IP_RDY = 1'b0;
    endtask

    task automatic handshake(input int hold);
        tick(hold);
        ARD_ACK = 1'b1;
        tick(3);
        exp_valid = 1'b0;
        tick(int'($urandom_range(1, 5)));
        ARD_ACK = 1'b0;
        tick(3);
        exp_busy = 1'b0;
        tick(2);
    endtask

    task automatic random_plan(input int miss_odds);
        for (int i = 1; i <= MAXF; i++) begin
            fr_miss[i] = ($urandom_range(0, miss_odds) == 0);
            case ($urandom_range(0, 2))
                0:       fr_res[i] = 4'h5;
                1:       fr_res[i] = 4'h6;
                default: fr_res[i] = 4'h9;
            endcase
        end
    endtask

    initial begin
        RESET_N = 1'b0; SCAN_REQ = 1'b0; VGA_VSYNC_NEG = 1'b1;
        IP_RESULT = 4'd0; IP_RDY = 1'b0; ARD_ACK = 1'b0;
        mon_en = 1'b1;
        tick(3);
        chk("reset_valid", 32'(ARD_VALID), 32'd0);
        chk("reset_busy",  32'(BUSY),      32'd0);
        chk("reset_data",  32'(ARD_DATA),  32'd0);
        chk("reset_timeout", 32'(ARD_TIMEOUT), 32'd0);
        RESET_N = 1'b1;

        // Agreement on RED DIAMOND.
        for (int i = 1; i <= MAXF; i++) begin
            fr_miss[i] = 1'b0; fr_res[i] = make_result(COLOUR_RED, SHAPE_DIAMOND);
        end
        model();
        chk("model_agree_k", 32'(m_k), 32'd3);
        chk("model_agree_d", 32'(m_d), 32'hB);
        chk("model_agree_to", 32'(m_to), 32'd0);
        run_scan(1'b0);
        handshake(100);

        // Disagreement resets the run.
        fr_res[1] = 4'h5; fr_res[2] = 4'h5;
        for (int i = 3; i <= MAXF; i++) fr_res[i] = 4'h9;
        model();
        chk("model_dis_k", 32'(m_k), 32'd5);
        chk("model_dis_d", 32'(m_d), 32'h9);
        run_scan(1'b0);
        handshake(7);

        // Alternating results time out.
        for (int i = 1; i <= MAXF; i++) fr_res[i] = (i % 2 == 1) ? 4'h5 : 4'h6;
        model();
        chk("model_alt_k", 32'(m_k), 32'd15);
        chk("model_alt_to", 32'(m_to), 32'd1);
        run_scan(1'b0);
        handshake(4);

        // All frames missed, with a stray scan request mid-scan.
        for (int i = 1; i <= MAXF; i++) fr_miss[i] = 1'b1;
        model();
        chk("model_miss_k", 32'(m_k), 32'd15);
        chk("model_miss_to", 32'(m_to), 32'd1);
        run_scan(1'b1);
        handshake(10);

        // Reset between clock edges while reporting.
        for (int i = 1; i <= MAXF; i++) begin
            fr_miss[i] = 1'b0; fr_res[i] = 4'h3;
        end
        run_scan(1'b0);
        tick(5);
        #2;
        RESET_N = 1'b0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_data = 4'd0; exp_to = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ARD_VALID), 32'd0);
        chk("rst_mid_data",  32'(ARD_DATA),  32'd0);
        chk("rst_mid_busy",  32'(BUSY),      32'd0);
        tick(2);
        RESET_N = 1'b1;

        // Randomized scans.
        for (int s = 0; s < 12; s++) begin
            random_plan((s % 2 == 0) ? 5 : 12);
            if (s % 3 == 0) for (int i = 4; i <= 6; i++) begin
                fr_miss[i] = 1'b0; fr_res[i] = 4'($urandom);
            end
            run_scan(s % 4 == 1);
            handshake(int'($urandom_range(1, 20)));
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
